// File: rtl/ccta_pkg.sv
// Shared types and helpers for the CCTA window accumulator: widths, FSM state
// enum and the bundled per-window statistics.
package ccta_pkg;

  localparam int Q_W   = 5;
  localparam int SUM_W = 13;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  typedef struct packed {
    logic [SUM_W-1:0] sum;
    logic [Q_W-1:0]   min_val;
    logic [Q_W-1:0]   max_val;
    logic [7:0]       count;
    logic             mode;
  } win_stats_t;

  function automatic win_stats_t start_stats(input logic [Q_W-1:0] q, input logic mode);
    win_stats_t s;
    s.sum     = {{(SUM_W-Q_W){1'b0}}, q};
    s.min_val = q;
    s.max_val = q;
    s.count   = 8'd1;
    s.mode    = mode;
    return s;
  endfunction

  // Fold one more sample into running stats; min/max are unsigned compares.
  function automatic win_stats_t fold_stats(input win_stats_t s, input logic [Q_W-1:0] q);
    win_stats_t r;
    r         = s;
    r.sum     = s.sum + {{(SUM_W-Q_W){1'b0}}, q};
    r.min_val = (q < s.min_val) ? q : s.min_val;
    r.max_val = (q > s.max_val) ? q : s.max_val;
    r.count   = s.count + 8'd1;
    return r;
  endfunction

endpackage

// File: rtl/ccta_out_hold.sv
// One-deep valid/ready holding register for finished windows, with a sticky
// overrun flag raised when a window arrives while the held one is stalled.
module ccta_out_hold
  import ccta_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       load,
  input  win_stats_t load_stats,
  input  logic       out_ready,
  output logic       out_valid,
  output win_stats_t out_stats,
  output logic       overrun
);

  logic       valid_q, valid_d;
  logic       overrun_q, overrun_d;
  win_stats_t stats_q, stats_d;

  // A load replaces the held window only if the slot is free or is being
  // retired on this same edge; otherwise the new window is dropped.
  always_comb begin
    valid_d   = valid_q;
    stats_d   = stats_q;
    overrun_d = overrun_q;
    if (load) begin
      if (!valid_q || out_ready) begin
        valid_d = 1'b1;
        stats_d = load_stats;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (clr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      stats_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      stats_q   <= stats_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_valid = valid_q;
  assign out_stats = stats_q;
  assign overrun   = overrun_q;

endmodule

// File: rtl/ccta_window_accum.sv
// Accumulates CCTA result samples into windows (sum/min/max/count/mode),
// closing on a full window or a mode change, and hands them to ccta_out_hold.
module ccta_window_accum #(
  parameter int WIN_LEN = 8,
  parameter int Q_W     = 5,
  parameter int SUM_W   = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Q_W-1:0]   q_in,
  input  logic             q_valid,
  input  logic             ctrl_in,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [Q_W-1:0]   out_min,
  output logic [Q_W-1:0]   out_max,
  output logic [7:0]       out_count,
  output logic             out_mode,
  output logic             overrun
);

  import ccta_pkg::*;

  localparam logic [7:0] WIN_CNT = 8'(WIN_LEN);

  state_t     state_q, state_d;
  win_stats_t acc_q, acc_d;
  win_stats_t upd;
  win_stats_t close_stats;
  win_stats_t hold_stats;
  logic       load;

  // clr wins over q_valid; a mode change closes the current stats and the
  // triggering sample seeds the next window without leaving ST_ACCUM.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    load        = 1'b0;
    close_stats = acc_q;
    upd         = fold_stats(acc_q, q_in);
    if (clr) begin
      state_d = ST_EMPTY;
      acc_d   = '0;
    end else if (q_valid) begin
      case (state_q)
        ST_EMPTY: begin
          acc_d   = start_stats(q_in, ctrl_in);
          state_d = ST_ACCUM;
        end
        ST_ACCUM: begin
          if (ctrl_in == acc_q.mode) begin
            if (upd.count == WIN_CNT) begin
              close_stats = upd;
              load        = 1'b1;
              acc_d       = '0;
              state_d     = ST_EMPTY;
            end else begin
              acc_d = upd;
            end
          end else begin
            close_stats = acc_q;
            load        = 1'b1;
            acc_d       = start_stats(q_in, ctrl_in);
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

  ccta_out_hold u_out_hold (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .load       (load),
    .load_stats (close_stats),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_stats  (hold_stats),
    .overrun    (overrun)
  );

  assign out_sum   = hold_stats.sum;
  assign out_min   = hold_stats.min_val;
  assign out_max   = hold_stats.max_val;
  assign out_count = hold_stats.count;
  assign out_mode  = hold_stats.mode;

endmodule
